// File: rtl/i2c_eeprom_seq_pkg.sv
// Shared types for the I2C EEPROM transaction sequencer: FSM states, response
// codes and the byte-controller command word.
package i2c_eeprom_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_W,
    POLL_STOP,
    ADDR_HI,
    ADDR_LO,
    WR_DATA,
    DEV_R,
    RD_DATA,
    ERR_STOP,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK   = 2'b00,
    ERR_NACK = 2'b01,
    ERR_AL   = 2'b10,
    ERR_TMO  = 2'b11
  } rsp_err_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       write;
    logic       read;
    logic       ack;
    logic [7:0] txd;
  } bc_cmd_t;

  // Byte-controller command issued on entry to each bus-phase state.
  function automatic bc_cmd_t cmd_for_state(input state_e     st,
                                            input logic [6:0] dev,
                                            input logic [15:0] addr,
                                            input logic [7:0] wdata);
    bc_cmd_t c;
    c = '0;
    unique case (st)
      DEV_W:     begin c.start = 1'b1; c.write = 1'b1; c.txd = {dev, 1'b0}; end
      ADDR_HI:   begin c.write = 1'b1; c.txd = addr[15:8]; end
      ADDR_LO:   begin c.write = 1'b1; c.txd = addr[7:0]; end
      WR_DATA:   begin c.write = 1'b1; c.stop = 1'b1; c.txd = wdata; end
      DEV_R:     begin c.start = 1'b1; c.write = 1'b1; c.txd = {dev, 1'b1}; end
      RD_DATA:   begin c.read = 1'b1; c.ack = 1'b1; c.stop = 1'b1; end
      POLL_STOP,
      ERR_STOP:  c.stop = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_eeprom_seq.sv
// Single-byte read/write sequencer for a 16-bit-addressed I2C EEPROM, driving
// an I2C byte controller one command at a time with retry, AL and timeout handling.
module i2c_eeprom_seq
  import i2c_eeprom_seq_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h2A,
  parameter int unsigned MAX_RETRY      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic        bc_start_o,
  output logic        bc_stop_o,
  output logic        bc_write_o,
  output logic        bc_read_o,
  output logic        bc_ack_o,
  output logic [7:0]  bc_txd_o,
  input  logic        bc_done_i,
  input  logic        bc_rxack_i,
  input  logic [7:0]  bc_rxd_i,
  input  logic        bc_al_i
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e         state_q, state_d;
  logic           we_q, we_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [7:0]     rdata_q, rdata_d;
  rsp_err_t       err_q, err_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  bc_cmd_t        cmd_q, cmd_d;
  logic           issued_q, issued_d;
  logic           tmo_hit;

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && issued_q && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    retry_d  = retry_q;
    tmo_d    = tmo_q;
    cmd_d    = cmd_q;
    issued_d = issued_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          err_d   = ERR_OK;
          retry_d = '0;
          state_d = DEV_W;
        end
      end

      RESP: state_d = IDLE;

      default: begin
        if (bc_al_i) begin
          // Bus is no longer ours: abandon without a STOP.
          cmd_d    = '0;
          issued_d = 1'b0;
          err_d    = ERR_AL;
          state_d  = RESP;
        end else if (!issued_q) begin
          cmd_d    = cmd_for_state(state_q, DEV_ADDR, addr_q, wdata_q);
          issued_d = 1'b1;
          tmo_d    = '0;
        end else if (bc_done_i) begin
          cmd_d    = '0;
          issued_d = 1'b0;
          unique case (state_q)
            DEV_W: begin
              if (!bc_rxack_i) begin
                state_d = ADDR_HI;
              end else if (32'(retry_q) < MAX_RETRY) begin
                retry_d = retry_q + RW'(1);
                state_d = POLL_STOP;
              end else begin
                err_d   = ERR_NACK;
                state_d = ERR_STOP;
              end
            end
            POLL_STOP: state_d = DEV_W;
            ADDR_HI: begin
              if (bc_rxack_i) begin err_d = ERR_NACK; state_d = ERR_STOP; end
              else            state_d = ADDR_LO;
            end
            ADDR_LO: begin
              if (bc_rxack_i) begin err_d = ERR_NACK; state_d = ERR_STOP; end
              else            state_d = we_q ? WR_DATA : DEV_R;
            end
            WR_DATA: begin
              // STOP already went out with the data byte.
              err_d   = bc_rxack_i ? ERR_NACK : ERR_OK;
              state_d = RESP;
            end
            DEV_R: begin
              if (bc_rxack_i) begin err_d = ERR_NACK; state_d = ERR_STOP; end
              else            state_d = RD_DATA;
            end
            RD_DATA: begin
              rdata_d = bc_rxd_i;
              state_d = RESP;
            end
            ERR_STOP: state_d = RESP;
            default:  state_d = IDLE;
          endcase
        end else if (tmo_hit) begin
          cmd_d    = '0;
          issued_d = 1'b0;
          err_d    = ERR_TMO;
          state_d  = RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
      retry_q  <= '0;
      tmo_q    <= '0;
      cmd_q    <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      cmd_q    <= cmd_d;
      issued_q <= issued_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 8'h00;
  assign rsp_err_o   = rsp_valid_o ? err_q : ERR_OK;

  assign bc_start_o  = cmd_q.start;
  assign bc_stop_o   = cmd_q.stop;
  assign bc_write_o  = cmd_q.write;
  assign bc_read_o   = cmd_q.read;
  assign bc_ack_o    = cmd_q.ack;
  assign bc_txd_o    = cmd_q.txd;

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// Self-checking bench: two sequencers (retry limits 8 and 2) share a behavioural
// byte controller + EEPROM model; results are compared to spec-level expectations.
`timescale 1ns/1ps
module tb_i2c_eeprom_seq;

  localparam logic [6:0] DEV     = 7'h2A;
  localparam int         TMO     = 16;
  localparam int         RETRY_A = 8;
  localparam int         RETRY_B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_we    [2];
  logic [15:0] req_addr [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic [1:0] rsp_err   [2];
  logic       bc_start  [2];
  logic       bc_stop   [2];
  logic       bc_write  [2];
  logic       bc_read   [2];
  logic       bc_ack    [2];
  logic [7:0] bc_txd    [2];
  logic       bc_done   [2];
  logic       bc_al     [2];

  logic       done_drv = 1'b0;
  logic       al_drv = 1'b0;
  logic       rxack_drv = 1'b0;
  logic [7:0] rxd_drv = 8'h00;
  int         sel = 0;
  bit         withhold = 0;
  bit         withhold_read = 0;
  int         al_index = -1;

  always_comb begin
    bc_done[0] = done_drv && (sel == 0);
    bc_done[1] = done_drv && (sel == 1);
    bc_al[0]   = al_drv && (sel == 0);
    bc_al[1]   = al_drv && (sel == 1);
  end

  i2c_eeprom_seq #(.DEV_ADDR(DEV), .MAX_RETRY(RETRY_A), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]),
    .bc_start_o(bc_start[0]), .bc_stop_o(bc_stop[0]), .bc_write_o(bc_write[0]),
    .bc_read_o(bc_read[0]), .bc_ack_o(bc_ack[0]), .bc_txd_o(bc_txd[0]),
    .bc_done_i(bc_done[0]), .bc_rxack_i(rxack_drv), .bc_rxd_i(rxd_drv), .bc_al_i(bc_al[0])
  );

  i2c_eeprom_seq #(.DEV_ADDR(DEV), .MAX_RETRY(RETRY_B), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]),
    .bc_start_o(bc_start[1]), .bc_stop_o(bc_stop[1]), .bc_write_o(bc_write[1]),
    .bc_read_o(bc_read[1]), .bc_ack_o(bc_ack[1]), .bc_txd_o(bc_txd[1]),
    .bc_done_i(bc_done[1]), .bc_rxack_i(rxack_drv), .bc_rxd_i(rxd_drv), .bc_al_i(bc_al[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Command word as seen on the bus: txd only matters for writes, ack only for reads.
  function automatic logic [12:0] enc(input logic s, input logic p, input logic w,
                                      input logic r, input logic a, input logic [7:0] d);
    return {s, p, w, r, r & a, w ? d : 8'h00};
  endfunction

  // EEPROM model: device-level protocol, memory committed on STOP.
  logic [7:0] mem     [bit [15:0]];
  logic [7:0] exp_mem [bit [15:0]];
  int         nack_budget = 0;
  int         phase = 0;          // 0 expect dev addr, 1 addr hi, 2 addr lo, 3 write data, 4 reading
  logic [15:0] ptr = '0;
  bit         pend_valid = 0;
  logic [15:0] pend_addr = '0;
  logic [7:0] pend_data = '0;
  logic [12:0] cmd_log [$];

  task automatic eeprom_byte(input logic s, input logic p, input logic w, input logic r,
                             input logic [7:0] d, output logic nack, output logic [7:0] rx);
    nack = 1'b1;
    rx   = 8'hFF;
    if (s) begin phase = 0; pend_valid = 0; end
    if (w) begin
      if (phase == 0) begin
        if (s && d[7:1] == DEV) begin
          if (nack_budget > 0) nack_budget--;
          else begin nack = 1'b0; phase = d[0] ? 4 : 1; end
        end
      end else if (phase == 1) begin ptr[15:8] = d; phase = 2; nack = 1'b0; end
      else if (phase == 2) begin ptr[7:0] = d; phase = 3; nack = 1'b0; end
      else if (phase == 3) begin
        pend_valid = 1; pend_addr = ptr; pend_data = d; ptr = ptr + 16'd1; nack = 1'b0;
      end
    end
    if (r && phase == 4) begin
      rx  = mem.exists(ptr) ? mem[ptr] : 8'hFF;
      ptr = ptr + 16'd1;
    end
    if (p) begin
      if (pend_valid) mem[pend_addr] = pend_data;
      pend_valid = 0;
      phase = 0;
    end
  endtask

  // Behavioural byte controller: answers each held command after a random delay.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !withhold &&
          (bc_start[sel] || bc_stop[sel] || bc_write[sel] || bc_read[sel]) &&
          !(withhold_read && bc_read[sel])) begin
        logic [12:0] c;
        logic        nk;
        logic [7:0]  rx;
        logic        s, p, w, r;
        logic [7:0]  d;
        s = bc_start[sel]; p = bc_stop[sel]; w = bc_write[sel]; r = bc_read[sel]; d = bc_txd[sel];
        c = enc(s, p, w, r, bc_ack[sel], d);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (al_index == cmd_log.size()) begin
          al_drv = 1'b1; al_index = -1; nk = 1'b1; rx = 8'h00;
        end else begin
          eeprom_byte(s, p, w, r, d, nk, rx);
        end
        cmd_log.push_back(c);
        rxack_drv = nk; rxd_drv = rx; done_drv = 1'b1;
        @(negedge clk);
        done_drv = 1'b0; al_drv = 1'b0; rxack_drv = 1'b0; rxd_drv = 8'h00;
      end
    end
  end

  task automatic run_txn(input string tag, input int which, input logic we,
                         input logic [15:0] addr, input logic [7:0] wdata,
                         input int nacks, input int max_retry, input int al_at);
    logic [12:0] exp_q [$];
    logic [1:0]  exp_err;
    logic [7:0]  exp_rd;
    bit          got;
    exp_err = 2'b00;
    for (int k = 0; k <= nacks; k++) begin
      exp_q.push_back(enc(1, 0, 1, 0, 0, {DEV, 1'b0}));
      if (k == nacks) break;
      exp_q.push_back(enc(0, 1, 0, 0, 0, 8'h00));
      if (k >= max_retry) begin exp_err = 2'b01; break; end
    end
    if (exp_err == 2'b00) begin
      exp_q.push_back(enc(0, 0, 1, 0, 0, addr[15:8]));
      exp_q.push_back(enc(0, 0, 1, 0, 0, addr[7:0]));
      if (we) exp_q.push_back(enc(0, 1, 1, 0, 0, wdata));
      else begin
        exp_q.push_back(enc(1, 0, 1, 0, 0, {DEV, 1'b1}));
        exp_q.push_back(enc(0, 1, 0, 1, 1, 8'h00));
      end
    end
    if (al_at >= 0) begin
      while (exp_q.size() > al_at + 1) void'(exp_q.pop_back());
      exp_err = 2'b10;
    end
    exp_rd = 8'h00;
    if (exp_err == 2'b00) begin
      if (we) exp_mem[addr] = wdata;
      else    exp_rd = exp_mem.exists(addr) ? exp_mem[addr] : 8'hFF;
    end

    sel = which; nack_budget = nacks; al_index = al_at; cmd_log.delete();
    @(negedge clk);
    check({tag, " ready_before"}, req_ready[sel], 1);
    req_we[sel] = we; req_addr[sel] = addr; req_wdata[sel] = wdata; req_valid[sel] = 1'b1;
    @(negedge clk);
    req_valid[sel] = 1'b0;
    req_we[sel] = ~we; req_addr[sel] = 16'($urandom); req_wdata[sel] = 8'($urandom);
    got = 0;
    for (int n = 0; n < 2000 && !got; n++) begin
      if (rsp_valid[sel]) got = 1;
      else @(negedge clk);
    end
    check({tag, " rsp_seen"}, got, 1);
    if (got) begin
      check({tag, " err"}, rsp_err[sel], exp_err);
      check({tag, " rdata"}, rsp_rdata[sel], exp_rd);
      check({tag, " ncmds"}, cmd_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
        check($sformatf("%s cmd%0d", tag, i), cmd_log[i], exp_q[i]);
      @(negedge clk);
      check({tag, " pulse_once"}, rsp_valid[sel], 0);
      check({tag, " ready_after"}, req_ready[sel], 1);
    end
    nack_budget = 0; al_index = -1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit seen;
    logic [15:0] addrs [6];
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_we[i] = 0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    addrs[0] = 16'h1234; addrs[1] = 16'h00FF; addrs[2] = 16'h4000;
    addrs[3] = 16'hFFFF; addrs[4] = 16'h0000; addrs[5] = 16'h0A0B;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset ready%0d", i), req_ready[i], 1);
      check($sformatf("reset outs%0d", i),
            {rsp_valid[i], rsp_rdata[i], rsp_err[i], bc_start[i], bc_stop[i],
             bc_write[i], bc_read[i], bc_ack[i], bc_txd[i]}, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn("wr1234", 0, 1'b1, 16'h1234, 8'hA5, 0, RETRY_A, -1);
    run_txn("rd1234", 0, 1'b0, 16'h1234, 8'h00, 0, RETRY_A, -1);
    run_txn("wr_retry3", 0, 1'b1, 16'h00FF, 8'h3C, 3, RETRY_A, -1);
    run_txn("rd_retry3", 0, 1'b0, 16'h00FF, 8'h00, 3, RETRY_A, -1);
    run_txn("wr_retry_exhaust", 1, 1'b1, 16'h0100, 8'h11, 3, RETRY_B, -1);
    run_txn("rd_retry_edge", 1, 1'b0, 16'h1234, 8'h00, 2, RETRY_B, -1);
    run_txn("al_addr_lo", 0, 1'b1, 16'h4000, 8'h77, 0, RETRY_A, 2);
    run_txn("rd_after_al", 0, 1'b0, 16'h4000, 8'h00, 0, RETRY_A, -1);

    // Timeout: byte controller never answers.
    sel = 0; withhold = 1;
    @(negedge clk);
    req_we[0] = 1'b1; req_addr[0] = 16'h2222; req_wdata[0] = 8'h5A; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int n = 0; n < 50 && !bc_start[0]; n++) @(negedge clk);
    check("tmo issued", bc_start[0], 1);
    cnt = 0;
    while (!rsp_valid[0] && cnt < 100) begin @(negedge clk); cnt++; end
    check("tmo latency", cnt, TMO);
    check("tmo err", rsp_err[0], 2'b11);
    check("tmo bc_dropped", {bc_start[0], bc_stop[0], bc_write[0], bc_read[0]}, 0);
    @(negedge clk);
    check("tmo ready_after", req_ready[0], 1);
    withhold = 0;

    // Reset while the read byte is outstanding.
    withhold_read = 1;
    @(negedge clk);
    req_we[0] = 1'b0; req_addr[0] = 16'h1234; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int n = 0; n < 300 && !bc_read[0]; n++) @(negedge clk);
    check("rst read_issued", bc_read[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst bc_cleared", {bc_start[0], bc_stop[0], bc_write[0], bc_read[0], bc_ack[0], bc_txd[0]}, 0);
    check("rst ready", req_ready[0], 1);
    check("rst no_rsp", rsp_valid[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    withhold_read = 0;
    seen = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid[0]) seen = 1; end
    check("rst no_rsp_after", seen, 0);
    check("rst ready_after", req_ready[0], 1);

    for (int t = 0; t < 24; t++) begin
      int          which, nacks, al_at;
      logic        we;
      logic [15:0] a;
      which = $urandom_range(0, 1);
      we    = 1'($urandom_range(0, 1));
      a     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 5)];
      nacks = $urandom_range(0, 4);
      al_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1;
      run_txn($sformatf("rnd%0d", t), which, we, a, 8'($urandom), nacks,
              (which == 0) ? RETRY_A : RETRY_B, al_at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
